// File: rtl/sign_apply.sv
// sign_apply: rebuilds a signed two's-complement value from a sign bit and an
// unsigned magnitude, saturating to the representable range. Two-stage elastic
// pipeline (S1 = registered inputs, S2 = registered result) with a saturating
// count of saturated results delivered downstream.
//
// Handshake: a transfer happens on a port only on a rising edge where both
// valid and ready are 1. A producer holds valid and data steady until ready is
// seen. in_sign/in_mag are ignored while in_valid=0, and out_ready is ignored
// while out_valid=0. in_ready depends combinationally on out_ready.
`timescale 1ns/1ps
module sign_apply #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [DWIDTH-1:0] in_mag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_sat,
    output logic [15:0]       sat_count,
    input  logic              sat_clr
);

    // Most positive and most negative representable results.
    localparam logic [DWIDTH-1:0] MAXP = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] MINN = {1'b1, {(DWIDTH-1){1'b0}}};

    // Stage S1: registered input item.
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [DWIDTH-1:0] s1_mag_q,   s1_mag_d;

    // Stage S2: registered result, drives the output port directly.
    logic              s2_valid_q, s2_valid_d;
    logic [DWIDTH-1:0] s2_data_q,  s2_data_d;
    logic              s2_sat_q,   s2_sat_d;

    logic [15:0]       sat_count_q, sat_count_d;

    logic              s2_adv;
    logic              in_fire;
    logic              out_fire;
    logic [DWIDTH-1:0] calc_data;
    logic              calc_sat;
    logic              mag_msb;
    logic              mag_low_nz;

    // Handshake qualifiers: S2 moves when empty or drained this cycle.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;
    end

    // Signed reconstruction of the S1 item with saturation to [MINN, MAXP].
    // A negative magnitude of exactly 2^(DWIDTH-1) negates to MINN exactly,
    // and negative zero negates to zero, so neither saturates.
    always_comb begin
        mag_msb    = s1_mag_q[DWIDTH-1];
        mag_low_nz = |s1_mag_q[DWIDTH-2:0];
        calc_data  = s1_mag_q;
        calc_sat   = 1'b0;
        if (!s1_sign_q) begin
            if (mag_msb) begin
                calc_data = MAXP;
                calc_sat  = 1'b1;
            end
        end else begin
            if (mag_msb && mag_low_nz) begin
                calc_data = MINN;
                calc_sat  = 1'b1;
            end else begin
                calc_data = -s1_mag_q;
            end
        end
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        // S1 empties when its item moves on; a new accept refills it.
        if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_sign;
            s1_mag_d   = in_mag;
        end
        // S2 only changes when it advances, so output holds during a stall.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = calc_data;
                s2_sat_d  = calc_sat;
            end
        end
    end

    // Saturated-output counter: clear wins, sticks at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = 16'h0000;
        end else if (out_fire && s2_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'h0001;
        end
    end

    // State registers with asynchronous reset that empties both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= 16'h0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Output port mapping.
    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_sat   = s2_sat_q;
        sat_count = sat_count_q;
    end

endmodule

// File: tb/tb_sign_apply.sv
// Testbench for sign_apply (DWIDTH=16): directed sequences plus a long random
// handshake run, scored against an integer reference model.
`timescale 1ns/1ps
module tb_sign_apply;

    localparam int W = 17;  // {sat, data}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [15:0] in_mag = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
    logic [15:0] sat_count;
    logic        sat_clr = 1'b0;

    sign_apply #(.DWIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    // ---------------- scoreboard state ----------------
    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [15:0]    exp_cnt = 16'h0000;
    bit             use_model = 1'b0;
    bit             prev_stall = 1'b0;
    logic [W-1:0]   prev_out = '0;
    int             n_in = 0;
    int             n_out = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer value, clamped to the 16-bit range.
    function automatic logic [W-1:0] model(input logic s, input logic [15:0] m);
        int v;
        v = s ? -int'(m) : int'(m);
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive inputs after the falling edge, then observe handshakes
    // and outputs in the quiet half before the next rising edge.
    task automatic drive(input logic v, input logic s, input logic [15:0] m,
                         input logic ordy, input logic clr);
        logic [W-1:0] e;
        @(negedge clk);
        in_valid  = v;
        in_sign   = s;
        in_mag    = m;
        out_ready = ordy;
        sat_clr   = clr;
        #2;
        check("sat_count", 32'(sat_count), 32'(exp_cnt));
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'({out_sat, out_data}), 32'(prev_out));
        end
        if (in_valid && in_ready) begin
            n_in++;
            if (use_model) exp_q.push_back(model(s, m));
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("extra_output", 32'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("out", 32'({out_sat, out_data}), 32'(e));
                if (e[16] && (exp_cnt != 16'hFFFF)) exp_cnt++;
            end
        end
        if (clr) exp_cnt = 16'h0000;
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_sat, out_data};
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_sat_count", 32'(sat_count), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        exp_cnt    = 16'h0000;
        prev_stall = 1'b0;
    endtask

    // Hang guard.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic        s040[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] m040[5]   = '{16'd5, 16'd5, 16'd0, 16'd32767, 16'd32768};
    logic        v040[8]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        s041[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] m041[4]   = '{16'd32768, 16'd65535, 16'd32769, 16'd65535};
    logic        v044[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] edge_m[6] = '{16'd0, 16'd1, 16'd32767, 16'd32768, 16'd32769, 16'd65535};

    initial begin
        // Reset state, held from time zero.
        #1;
        check("init_out_valid", 32'(out_valid), 0);
        check("init_out_data", 32'(out_data), 0);
        check("init_out_sat", 32'(out_sat), 0);
        check("init_sat_count", 32'(sat_count), 0);
        check("init_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 1);

        // Back-to-back non-saturating values, two-cycle latency.
        use_model = 1'b0;
        exp_q.push_back({1'b0, 16'h0005});
        exp_q.push_back({1'b0, 16'hFFFB});
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b0, 16'h7FFF});
        exp_q.push_back({1'b0, 16'h8000});
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(1'b1, s040[i], m040[i], 1'b1, 1'b0);
            else       drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            check("latency_valid", 32'(out_valid), 32'(v040[i]));
        end
        check("drain_040", 32'(exp_q.size()), 0);

        // Saturating values in both directions.
        exp_q.push_back({1'b1, 16'h7FFF});
        exp_q.push_back({1'b1, 16'h7FFF});
        exp_q.push_back({1'b1, 16'h8000});
        exp_q.push_back({1'b1, 16'h8000});
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, s041[i], m041[i], 1'b1, 1'b0);
            else       drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check("drain_041", 32'(exp_q.size()), 0);
        check("sat_count_4", 32'(sat_count), 4);

        // Output stall: S2 holds, S1 fills, input back-pressured, then drains.
        exp_q.push_back({1'b0, 16'h0064});
        exp_q.push_back({1'b0, 16'hFF38});
        drive(1'b1, 1'b0, 16'd100, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd200, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'd300, 1'b0, 1'b0);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_out_data", 32'(out_data), 32'h0064);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("drain_042", 32'(exp_q.size()), 0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("idle_after_042", 32'(out_valid), 0);

        // Saturation counter ceiling and clear priority.
        pulse_reset();
        use_model = 1'b1;
        for (int i = 0; i < 65535 + 3; i++) drive(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("sat_count_ceiling", 32'(sat_count), 32'h0000FFFF);
        drive(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("clr_with_sat_out", 32'({out_valid, out_sat}), 32'h3);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("sat_count_cleared", 32'(sat_count), 0);

        // Reset with both stages full: nothing stale afterwards.
        use_model = 1'b0;
        drive(1'b1, 1'b0, 16'd1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        pulse_reset();
        exp_q.push_back({1'b0, 16'hFFF9});
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 16'd7, 1'b1, 1'b0);
            else        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            check("post_rst_valid", 32'(out_valid), 32'(v044[i]));
        end
        check("drain_044", 32'(exp_q.size()), 0);

        // Random handshakes against the reference model.
        pulse_reset();
        use_model = 1'b1;
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 40000 && n_in < 10000; i++) begin
            logic        rv;
            logic        rs;
            logic [15:0] rm;
            rv = ($urandom_range(0, 9) != 0);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rm = edge_m[$urandom_range(0, 5)];
            else                           rm = 16'($urandom_range(0, 65535));
            drive(rv, rs, rm, ($urandom_range(0, 9) != 0), 1'b0);
        end
        check("random_items_accepted", 32'(n_in), 10000);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check("random_drain", 32'(exp_q.size()), 0);
        check("random_in_eq_out", 32'(n_out), 32'(n_in));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
